sign_extension_unit: RTL and testbench
======================================

// Module: sign_extension_unit
// PURPOSE
//   Immediate-operand extender used by the Decode stage: widens the 16-bit IR[15:0]
//   immediate to the datapath word width. Provides a zero-latency combinational
//   result (Out, consumed directly by Decode) and a registered copy with valid flag
//   for pipelined consumers. Supports sign/zero extension of 16- or 8-bit fields.
// PARAMETERS
//   IN_WIDTH   16  width of input immediate field
//   OUT_WIDTH  32  width of extended result; must be >= IN_WIDTH
//   BYTE_WIDTH 8   width of narrow field used by byte modes
// PORTS
//   I_CLOCK    in   1          single clock; all state updates on rising edge
//   I_RESET_N  in   1          reset, asynchronous, active-low
//   I_LOCK     in   1          stage enable; register updates only when 1
//   In         in   IN_WIDTH   raw immediate (IR[15:0])
//   I_Mode     in   2          00 sext16, 01 zext16, 10 sext8, 11 zext8
//   I_Valid    in   1          input qualifier for registered path
//   Out        out  OUT_WIDTH  combinational extended value
//   O_OutReg   out  OUT_WIDTH  registered extended value
//   O_Valid    out  1          registered valid
// BEHAVIOUR
//   Combinational path: Out reflects In and I_Mode in the same cycle, no clock or
//   reset dependency. A module wired with only In/Out and I_Mode tied 2'b00 must
//   behave as a pure 16->32 sign extender.
//   - 00: Out = {{(OUT_WIDTH-16){In[15]}}, In[15:0]}
//   - 01: Out = {{(OUT_WIDTH-16){1'b0}}, In[15:0]}
//   - 10: Out = {{(OUT_WIDTH-8){In[7]}}, In[7:0]}; In[15:8] ignored
//   - 11: Out = {{(OUT_WIDTH-8){1'b0}}, In[7:0]}; In[15:8] ignored
//   - Out must not contain X for any known In/I_Mode.
//   Registered path:
//   - I_RESET_N low (async, any time): O_OutReg = 0, O_Valid = 0 immediately.
//     Values stay there while reset is held.
//   - Rising edge with I_RESET_N high and I_LOCK=1: O_OutReg <= Out, O_Valid <= I_Valid.
//     Latency is 1 cycle.
//   - Rising edge with I_LOCK=0: both registers hold their values.
//   - O_OutReg is updated even when I_Valid=0; consumers qualify it with O_Valid.
//   - Reset deassertion is synchronised by the user. The first capture happens on the
//     first rising edge after release.
//   - No internal state beyond O_OutReg and O_Valid; no handshake backpressure.
// TESTING
//   - I_Mode=00, In=16'h8000 -> Out=32'hFFFF8000. In=16'h7FFF -> Out=32'h00007FFF,
//     same cycle.
//   - I_Mode=01, In=16'h8000 -> Out=32'h00008000. I_Mode=10, In=16'h1280 ->
//     Out=32'hFFFFFF80. I_Mode=11, In=16'h1280 -> Out=32'h00000080.
//   - Registered path: I_LOCK=1, I_Valid=1, In=16'hFFFE, mode 00 -> after one rising
//     edge O_OutReg=32'hFFFFFFFE and O_Valid=1.
//   - Hold: capture 16'h0005, then I_LOCK=0 and In=16'h8001 for 3 edges ->
//     O_OutReg stays 32'h00000005.
//   - Async reset: drive I_RESET_N low between clock edges -> O_OutReg=0 and O_Valid=0
//     before the next edge. After release, the next enabled edge captures normally.
//   - Exhaustive sweep: all 65536 In values x 4 modes -> Out matches the reference
//     formulas above.

Source files
------------

// File: rtl/sign_extension_unit.sv
// Immediate extender for Decode: sign/zero extends a 16- or 8-bit field of IR[15:0]
// to the datapath width, with a combinational result and an enabled registered copy.
module sign_extension_unit #(
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned OUT_WIDTH  = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                 I_CLOCK,
  input  logic                 I_RESET_N,
  input  logic                 I_LOCK,
  input  logic [IN_WIDTH-1:0]  In,
  input  logic [1:0]           I_Mode,
  input  logic                 I_Valid,
  output logic [OUT_WIDTH-1:0] Out,
  output logic [OUT_WIDTH-1:0] O_OutReg,
  output logic                 O_Valid
);

  typedef enum logic [1:0] {
    MODE_SEXT_WORD = 2'b00,
    MODE_ZEXT_WORD = 2'b01,
    MODE_SEXT_BYTE = 2'b10,
    MODE_ZEXT_BYTE = 2'b11
  } ext_mode_e;

  ext_mode_e                     mode_c;
  logic signed [IN_WIDTH-1:0]    word_s;
  logic        [BYTE_WIDTH-1:0]  byte_u;
  logic signed [BYTE_WIDTH-1:0]  byte_s;
  logic        [OUT_WIDTH-1:0]   ext_c;

  logic [OUT_WIDTH-1:0] out_reg_q, out_reg_d;
  logic                 valid_q,   valid_d;

  assign mode_c = ext_mode_e'(I_Mode);
  assign word_s = In;
  assign byte_u = In[BYTE_WIDTH-1:0];
  assign byte_s = byte_u;

  // Size casts of signed operands replicate the field MSB; unsigned ones pad with zeros.
  always_comb begin
    ext_c = '0;
    case (mode_c)
      MODE_SEXT_WORD: ext_c = OUT_WIDTH'(word_s);
      MODE_ZEXT_WORD: ext_c = OUT_WIDTH'(In);
      MODE_SEXT_BYTE: ext_c = OUT_WIDTH'(byte_s);
      MODE_ZEXT_BYTE: ext_c = OUT_WIDTH'(byte_u);
      default:        ext_c = '0;
    endcase
  end

  assign Out = ext_c;

  // Capture whenever the stage is enabled; the data word updates regardless of I_Valid.
  always_comb begin
    out_reg_d = out_reg_q;
    valid_d   = valid_q;
    if (I_LOCK) begin
      out_reg_d = ext_c;
      valid_d   = I_Valid;
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      out_reg_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      out_reg_q <= out_reg_d;
      valid_q   <= valid_d;
    end
  end

  assign O_OutReg = out_reg_q;
  assign O_Valid  = valid_q;

endmodule

// File: tb/tb_sign_extension_unit.sv
// Bench for sign_extension_unit: directed vectors feed a scoreboard queue that a
// monitor drains after each rising edge; combinational results are checked inline.
module tb_sign_extension_unit;

  logic        I_CLOCK   = 1'b0;
  logic        I_RESET_N = 1'b1;
  logic        I_LOCK    = 1'b0;
  logic        I_Valid   = 1'b0;
  logic [15:0] In        = '0;
  logic [1:0]  I_Mode    = '0;
  logic [31:0] Out;
  logic [31:0] O_OutReg;
  logic        O_Valid;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    logic        v;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl_reg = '0;
  logic        mdl_v   = 1'b0;

  sign_extension_unit #(
    .IN_WIDTH  (16),
    .OUT_WIDTH (32),
    .BYTE_WIDTH(8)
  ) dut (
    .I_CLOCK  (I_CLOCK),
    .I_RESET_N(I_RESET_N),
    .I_LOCK   (I_LOCK),
    .In       (In),
    .I_Mode   (I_Mode),
    .I_Valid  (I_Valid),
    .Out      (Out),
    .O_OutReg (O_OutReg),
    .O_Valid  (O_Valid)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  function automatic logic [31:0] ref_ext(input logic [15:0] x, input logic [1:0] m);
    case (m)
      2'b00:   return {{16{x[15]}}, x};
      2'b01:   return {16'h0000, x};
      2'b10:   return {{24{x[7]}}, x[7:0]};
      default: return {24'h000000, x[7:0]};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, check Out in the same cycle, queue the register expectation.
  task automatic step(input string name, input logic lock, input logic valid,
                      input logic [1:0] mode, input logic [15:0] din,
                      input logic [31:0] exp_out);
    exp_t e;
    @(negedge I_CLOCK);
    I_LOCK  = lock;
    I_Valid = valid;
    I_Mode  = mode;
    In      = din;
    #1;
    check({name, "_out"}, Out, exp_out);
    if (lock) begin
      mdl_reg = exp_out;
      mdl_v   = valid;
    end
    e.data = mdl_reg;
    e.v    = mdl_v;
    e.tag  = name;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge I_CLOCK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.tag, "_outreg"}, O_OutReg, e.data);
        check({e.tag, "_valid"}, 32'(O_Valid), 32'(e.v));
      end
    end
  end

  initial begin : stimulus
    int          errs;
    logic [31:0] bad_got;
    logic [31:0] bad_exp;

    #1 I_RESET_N = 1'b0;
    #2;
    check("reset_outreg", O_OutReg, 32'h0);
    check("reset_valid", 32'(O_Valid), 32'h0);
    repeat (2) @(negedge I_CLOCK);
    I_RESET_N = 1'b1;

    step("sext16_neg",   1'b1, 1'b1, 2'b00, 16'h8000, 32'hFFFF8000);
    step("sext16_pos",   1'b1, 1'b1, 2'b00, 16'h7FFF, 32'h00007FFF);
    step("zext16",       1'b1, 1'b1, 2'b01, 16'h8000, 32'h00008000);
    step("sext8_neg",    1'b1, 1'b1, 2'b10, 16'h1280, 32'hFFFFFF80);
    step("zext8",        1'b1, 1'b1, 2'b11, 16'h1280, 32'h00000080);
    step("reg_fffe",     1'b1, 1'b1, 2'b00, 16'hFFFE, 32'hFFFFFFFE);
    step("novalid_upd",  1'b1, 1'b0, 2'b01, 16'hFFFE, 32'h0000FFFE);
    step("sext8_pos",    1'b1, 1'b1, 2'b10, 16'hAB7F, 32'h0000007F);
    step("zext8_ff",     1'b1, 1'b0, 2'b11, 16'h00FF, 32'h000000FF);
    step("sext8_80",     1'b1, 1'b1, 2'b10, 16'h0080, 32'hFFFFFF80);
    step("cap_5",        1'b1, 1'b1, 2'b00, 16'h0005, 32'h00000005);
    step("hold_1",       1'b0, 1'b0, 2'b00, 16'h8001, 32'hFFFF8001);
    step("hold_2",       1'b0, 1'b0, 2'b00, 16'h8001, 32'hFFFF8001);
    step("hold_3",       1'b0, 1'b0, 2'b00, 16'h8001, 32'hFFFF8001);
    step("cap_ones",     1'b1, 1'b1, 2'b01, 16'hFFFF, 32'h0000FFFF);

    // Assert reset mid-cycle, after the monitor has drained the last entry.
    @(posedge I_CLOCK);
    #3;
    I_RESET_N = 1'b0;
    #1;
    check("async_rst_outreg", O_OutReg, 32'h0);
    check("async_rst_valid", 32'(O_Valid), 32'h0);
    I_LOCK = 1'b1;
    I_Valid = 1'b1;
    repeat (2) @(posedge I_CLOCK);
    #2;
    check("rst_held_outreg", O_OutReg, 32'h0);
    check("rst_held_valid", 32'(O_Valid), 32'h0);
    mdl_reg = '0;
    mdl_v   = 1'b0;
    @(negedge I_CLOCK);
    I_RESET_N = 1'b1;
    step("post_rst_cap", 1'b1, 1'b1, 2'b00, 16'h1234, 32'h00001234);
    step("post_rst_hold", 1'b0, 1'b1, 2'b10, 16'h00C3, 32'hFFFFFFC3);

    @(negedge I_CLOCK);
    I_LOCK = 1'b0;
    for (int m = 0; m < 4; m++) begin
      errs    = 0;
      bad_got = '0;
      bad_exp = '0;
      for (int i = 0; i < 65536; i++) begin
        In     = 16'(i);
        I_Mode = 2'(m);
        #1;
        if (Out !== ref_ext(In, I_Mode)) begin
          if (errs == 0) begin
            bad_got = Out;
            bad_exp = ref_ext(In, I_Mode);
          end
          errs++;
        end
      end
      if (errs != 0)
        $display("first sweep divergence mode %0d: got %h expected %h", m, bad_got, bad_exp);
      check($sformatf("sweep_mode%0d_errors", m), 32'(errs), 32'd0);
    end
    check("hold_after_sweep", O_OutReg, 32'h00001234);

    repeat (3) @(posedge I_CLOCK);
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
